// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI slave types and default word width
package spi_pkg;
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;
  localparam int SPI_DATA_WIDTH = 8;
endpackage

// File: rtl/spi_slave_shifter.sv
// spi_slave_shifter: SPI mode-0 MSB-first slave shift engine fed by pre-detected SCLK edge pulses
module spi_slave_shifter
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  spi_cs_n_i,
  input  logic                  spi_mosi_i,
  input  logic                  sclk_pos_i,
  input  logic                  sclk_neg_i,
  output logic                  spi_miso_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_vld_o,
  output logic                  rx_first_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic                  tx_req_o
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  spi_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d, tx_q, tx_d, rx_data_q, rx_data_d;
  logic first_q, first_d, rx_vld_q, rx_vld_d, rx_first_q, rx_first_d, tx_req_q, tx_req_d;
  logic active, pos, neg, done;
  logic [DATA_WIDTH-1:0] rx_shift;
  assign active   = state_q == ACTIVE && !spi_cs_n_i;
  assign pos      = active && sclk_pos_i;
  assign neg      = active && sclk_neg_i;
  assign done     = pos && cnt_q == LAST;
  assign rx_shift = {rx_q[DATA_WIDTH-2:0], spi_mosi_i};
  // Next state: CS drives the FSM, edges act only while selected, word completion is registered one cycle later
  always_comb begin
    state_d    = spi_cs_n_i ? IDLE : ACTIVE;
    cnt_d      = cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    first_d    = first_q;
    rx_vld_d   = done;
    tx_req_d   = done;
    rx_data_d  = done ? rx_shift : rx_data_q;
    rx_first_d = done ? first_q : rx_first_q;
    if (state_q == IDLE && !spi_cs_n_i) begin
      cnt_d   = '0;
      first_d = 1'b1;
      tx_d    = tx_data_i;
    end else if (spi_cs_n_i) begin
      cnt_d = '0;
    end else if (pos) begin
      rx_d    = rx_shift;
      cnt_d   = done ? '0 : cnt_q + 1'b1;
      first_d = done ? 1'b0 : first_q;
    end else if (neg) begin
      tx_d = cnt_q == '0 ? tx_data_i : {tx_q[DATA_WIDTH-2:0], 1'b0};
    end
  end
  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      first_q    <= 1'b0;
      rx_data_q  <= '0;
      rx_vld_q   <= 1'b0;
      rx_first_q <= 1'b0;
      tx_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      first_q    <= first_d;
      rx_data_q  <= rx_data_d;
      rx_vld_q   <= rx_vld_d;
      rx_first_q <= rx_first_d;
      tx_req_q   <= tx_req_d;
    end
  end
  assign spi_miso_o = state_q == ACTIVE ? tx_q[DATA_WIDTH-1] : 1'b0;
  assign rx_data_o  = rx_data_q;
  assign rx_vld_o   = rx_vld_q;
  assign rx_first_o = rx_first_q;
  assign tx_req_o   = tx_req_q;
endmodule

// File: tb/tb_spi_slave_shifter.sv
// tb_spi_slave_shifter: scoreboard bench for the SPI slave shifter
module tb_spi_slave_shifter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic sp = 1'b0;
  logic sn = 1'b0;
  logic miso;
  logic [7:0] rx_data;
  logic rx_vld;
  logic rx_first;
  logic [7:0] tx_data = 8'h00;
  logic tx_req;
  int compared = 0;
  int mismatched = 0;
  int vld_cnt = 0;
  int req_cnt = 0;
  logic [8:0] exp_q[$];
  logic [7:0] txw_q[$];

  spi_slave_shifter dut (
    .clk_i(clk), .rst_i(rst), .spi_cs_n_i(cs_n), .spi_mosi_i(mosi),
    .sclk_pos_i(sp), .sclk_neg_i(sn), .spi_miso_o(miso),
    .rx_data_o(rx_data), .rx_vld_o(rx_vld), .rx_first_o(rx_first),
    .tx_data_i(tx_data), .tx_req_o(tx_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rx_vld) begin
      vld_cnt++;
      if (exp_q.size() == 0) chk("unexpected rx_vld", {23'd0, rx_first, rx_data}, 32'h1FF);
      else chk("rx word {first,data}", {23'd0, rx_first, rx_data}, {23'd0, exp_q.pop_front()});
    end
    if (tx_req) begin
      req_cnt++;
      if (txw_q.size() != 0) tx_data = txw_q.pop_front();
    end
  end

  task automatic sclk_bit(input logic b, output logic m);
    @(negedge clk) mosi = b;
    repeat (2) @(negedge clk);
    sp = 1'b1;
    m = miso;
    @(negedge clk) sp = 1'b0;
    repeat (3) @(negedge clk);
    sn = 1'b1;
    @(negedge clk) sn = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] mo, input int n, output logic [7:0] mi);
    logic m;
    mi = '0;
    for (int i = 0; i < n; i++) begin
      sclk_bit(mo[7-i], m);
      mi = {mi[6:0], m};
    end
  endtask

  task automatic cs_begin();
    @(negedge clk) cs_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic cs_end();
    @(negedge clk) cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] mi;
    int v0, r0;
    repeat (3) @(negedge clk);
    chk("reset miso", miso, 0);
    chk("reset rx_data", rx_data, 0);
    chk("reset rx_vld", rx_vld, 0);
    chk("reset rx_first", rx_first, 0);
    chk("reset tx_req", tx_req, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    v0 = vld_cnt; r0 = req_cnt;
    tx_data = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      sclk_bit(i[0], mi[0]);
      chk("idle miso", miso, 0);
    end
    chk("idle rx_vld count", vld_cnt - v0, 0);
    chk("idle tx_req count", req_cnt - r0, 0);
    tx_data = 8'h3C;
    exp_q.push_back({1'b1, 8'hA5});
    v0 = vld_cnt; r0 = req_cnt;
    cs_begin();
    xfer(8'hA5, 8, mi);
    chk("single miso word", mi, 8'h3C);
    cs_end();
    chk("single rx_vld count", vld_cnt - v0, 1);
    chk("single tx_req count", req_cnt - r0, 1);
    tx_data = 8'h55;
    txw_q.push_back(8'h81);
    exp_q.push_back({1'b1, 8'h12});
    exp_q.push_back({1'b0, 8'h34});
    v0 = vld_cnt;
    cs_begin();
    xfer(8'h12, 8, mi);
    chk("b2b miso word 1", mi, 8'h55);
    xfer(8'h34, 8, mi);
    chk("b2b miso word 2", mi, 8'h81);
    cs_end();
    chk("b2b rx_vld count", vld_cnt - v0, 2);
    v0 = vld_cnt;
    cs_begin();
    xfer(8'hF8, 5, mi);
    cs_end();
    chk("abort rx_vld count", vld_cnt - v0, 0);
    exp_q.push_back({1'b1, 8'hFF});
    cs_begin();
    xfer(8'hFF, 8, mi);
    cs_end();
    chk("abort+word rx_vld count", vld_cnt - v0, 1);
    chk("held rx_data", rx_data, 8'hFF);
    v0 = vld_cnt;
    tx_data = 8'hFF;
    cs_begin();
    xfer(8'h7E, 7, mi);
    @(negedge clk) mosi = 1'b1;
    repeat (2) @(negedge clk);
    sp = 1'b1;
    cs_n = 1'b1;
    @(negedge clk) sp = 1'b0;
    chk("collision miso", miso, 0);
    repeat (4) @(negedge clk);
    chk("collision rx_vld count", vld_cnt - v0, 0);
    v0 = vld_cnt;
    cs_begin();
    xfer(8'hE0, 3, mi);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("midreset miso", miso, 0);
    chk("midreset rx_data", rx_data, 0);
    chk("midreset rx_vld", rx_vld, 0);
    chk("midreset rx_first", rx_first, 0);
    chk("midreset tx_req", tx_req, 0);
    xfer(8'h1F, 5, mi);
    cs_end();
    chk("midreset rx_vld count", vld_cnt - v0, 0);
    exp_q.push_back({1'b1, 8'h5A});
    tx_data = 8'hC3;
    cs_begin();
    xfer(8'h5A, 8, mi);
    chk("post-reset miso word", mi, 8'hC3);
    cs_end();
    chk("post-reset rx_vld count", vld_cnt - v0, 1);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/spi_slave_shifter.md
SPI_SLAVE_SHIFTER -- requirements
Module: spi_slave_shifter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the bits per SPI word (legal values 2..32).
REQ-002 SHALL have port clk_i  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port spi_cs_n_i  input  1  chip select, active-low, already synchronised to clk_i.
REQ-005 SHALL have port spi_mosi_i  input  1  serial data in, already synchronised to clk_i.
REQ-006 SHALL have port sclk_pos_i  input  1  one-cycle pulse marking an SCLK rising edge (driven by the upstream edge detector's pos_edge_o).
REQ-007 SHALL have port sclk_neg_i  input  1  one-cycle pulse marking an SCLK falling edge (driven by the upstream edge detector's neg_edge_o).
REQ-008 SHALL have port spi_miso_o  output  1  serial data out.
REQ-009 SHALL have port rx_data_o  output  DATA_WIDTH  last completed received word.
REQ-010 SHALL have port rx_vld_o  output  1  one-cycle pulse, rx_data_o newly valid.
REQ-011 SHALL have port rx_first_o  output  1  qualifies rx_vld_o: high when the word is the first one since CS fell.
REQ-012 SHALL have port tx_data_i  input  DATA_WIDTH  next word to transmit.
REQ-013 SHALL have port tx_req_o  output  1  one-cycle pulse requesting tx_data_i for the next word.

Function
REQ-014 SHALL implement SPI mode 0, MSB first: sample MOSI on sclk_pos_i, shift MISO on sclk_neg_i.
REQ-015 SHALL use a two-state FSM: IDLE and ACTIVE.
- IDLE -> ACTIVE when spi_cs_n_i is low.
- ACTIVE -> IDLE when spi_cs_n_i is high.
REQ-016 SHALL, on IDLE -> ACTIVE, clear the bit counter, set the first-word flag, and load tx_data_i into the TX shift register so that spi_miso_o = tx_data_i[DATA_WIDTH-1] in the next cycle.
REQ-017 SHALL, in ACTIVE with sclk_pos_i high, shift spi_mosi_i into the LSB of the RX shift register and increment the bit counter, which wraps to 0 after reaching DATA_WIDTH-1.
REQ-018 SHALL, on the sclk_pos_i that completes bit DATA_WIDTH-1, do the following in the following cycle (latency 1 clk):
- pulse rx_vld_o and tx_req_o;
- drive rx_data_o with the full word;
- drive rx_first_o with the first-word flag, then clear that flag.
REQ-019 SHALL hold rx_data_o stable between rx_vld_o pulses; rx_first_o is don't-care when rx_vld_o is low.
REQ-020 SHALL, in ACTIVE with sclk_neg_i high, behave according to the bit counter:
- bit counter non-zero: shift the TX register left by one;
- bit counter zero (word boundary): reload the TX register from tx_data_i.
REQ-021 SHALL drive spi_miso_o from the TX register MSB in ACTIVE, and 0 in IDLE.
REQ-022 SHALL have the upstream present tx_data_i within 1 clk of tx_req_o, which requires an SCLK half-period of at least 3 clk.
REQ-023 SHALL, when spi_cs_n_i rises mid-word, discard the partial word: no rx_vld_o, and the bit counter is cleared.
REQ-024 SHALL give CS priority when spi_cs_n_i is high in the same cycle as sclk_pos_i or sclk_neg_i: the edge is ignored.
REQ-025 SHALL ignore sclk_pos_i and sclk_neg_i while in IDLE.
REQ-026 SHALL treat simultaneous sclk_pos_i and sclk_neg_i as illegal input; the response is unspecified.

Reset
REQ-027 SHALL, while rst_i is high at a clk_i edge, set:
- FSM to IDLE;
- bit counter, RX register, TX register and first-word flag to 0;
- spi_miso_o, rx_data_o, rx_vld_o, rx_first_o and tx_req_o to 0.
REQ-028 SHALL, when reset is asserted mid-word, drop the partial word with no rx_vld_o, and resume only after spi_cs_n_i is low in a cycle with rst_i low.

Structure
REQ-029 SHALL take its FSM state enum (IDLE, ACTIVE) from the shared package spi_pkg, together with the default word-width constant.
REQ-030 SHALL contain no sub-modules; SCLK edge detection is done upstream and fed in via sclk_pos_i and sclk_neg_i.

Verification
REQ-031 SHALL cover a single word: CS low, 8 SCLK cycles with MOSI = 0xA5, tx_data_i = 0x3C.
- Required: rx_vld_o pulses once with rx_data_o = 0xA5 and rx_first_o = 1.
- Required: MISO bits sampled on SCLK rise = 0x3C.
REQ-032 SHALL cover back-to-back words: MOSI 0x12 then 0x34 under one CS, with tx_data_i = 0x81 after the first tx_req_o.
- Required: two rx_vld_o pulses (0x12 with rx_first_o = 1, then 0x34 with rx_first_o = 0).
- Required: second MISO word = 0x81.
REQ-033 SHALL cover abort: CS rises after 5 bits, then a full word 0xFF.
- Required: exactly one rx_vld_o, with data 0xFF and rx_first_o = 1.
REQ-034 SHALL cover collision: CS rises in the same cycle as the 8th sclk_pos_i.
- Required: no rx_vld_o, and spi_miso_o = 0 the next cycle.
REQ-035 SHALL cover reset mid-word: rst_i high for 1 clk after 3 bits.
- Required: all outputs 0, no rx_vld_o until CS toggles and a full word is shifted.
REQ-036 SHALL cover idle edges: SCLK pulses with CS high.
- Required: no rx_vld_o or tx_req_o, and spi_miso_o stays 0.
